// File: rtl/ftd_input_packer.sv
// ---------------------------------------------------------------------------
// ftd_input_packer
//
// Purpose:
//   This is the transmit side of the GDL-to-FTD connector. It collects the
//   CDC, ECL, TOP and KLM trigger summaries into one frame per frame_start.
//   These summaries arrive with their own valid strobes and at different
//   latencies. Each frame is then packed onto the iob/iod/iof connector words.
//   A frame is emitted when all four sources have arrived, when the
//   collection window expires, or when a new frame_start overlaps it.
//
// Parameters:
//   WINDOW  collection window length in gclk2 cycles (2..255); the
//           frame_start cycle is window cycle 0.
//   FCNT_W  frame counter width (1..16).
//
// Ports:
//   gclk2, reset            clock (posedge) and synchronous active-high reset
//   frame_start             one-cycle pulse opening a frame
//   cdc_* / ecl_* / top_* / klm_*
//                           per-subsystem valid strobes and summary fields
//   revo .. veto            KEKB/GDL bits, sampled in the emission cycle
//   ftdinb, ftdind, ftdinf  registered connector words (iob, iod, iof)
//   ftd_frame_valid         one-cycle strobe marking new connector words
//
// Optional feature:
//   Define FTD_PARITY_EN to place parity in ftdinf[29:28]:
//   bit 28 is the XOR of ftdinb, and bit 29 is the XOR of ftdind[19:0].
//   When the macro is not defined, both bits are 0.
// ---------------------------------------------------------------------------
module ftd_input_packer #(
  parameter int WINDOW = 8,
  parameter int FCNT_W = 16
) (
  input  logic        gclk2,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        cdc_valid,
  input  logic [3:0]  cdc_t3_full,
  input  logic [3:0]  cdc_t3_short,
  input  logic [3:0]  cdc_t2_full,
  input  logic [3:0]  cdc_t2_short,
  input  logic        cdc_bb,
  input  logic        cdc_open45,
  input  logic        cdc_timing,
  input  logic        ecl_valid,
  input  logic [7:0]  ecl_flags,
  input  logic        e_high,
  input  logic [10:0] bha_type,
  input  logic [4:0]  n_clus_raw,
  input  logic        top_valid,
  input  logic [3:0]  n_top_raw,
  input  logic        top_bb,
  input  logic        klm_valid,
  input  logic [3:0]  n_klm_raw,
  input  logic        revo,
  input  logic        her_kick,
  input  logic        ler_kick,
  input  logic        bha_delay,
  input  logic        pseude_rand,
  input  logic        veto,
  output logic [31:0] ftdinb,
  output logic [31:0] ftdind,
  output logic [29:0] ftdinf,
  output logic        ftd_frame_valid
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam logic [7:0] LAST_CYC = 8'(WINDOW - 1);

  // Saturate a 4-bit count into 3 bits.
  function automatic logic [2:0] sat3(input logic [3:0] v);
    logic [2:0] r;
    if (v >= 4'd7) begin
      r = 3'd7;
    end else begin
      r = v[2:0];
    end
    return r;
  endfunction

  // Saturate a 5-bit count into 4 bits.
  function automatic logic [3:0] sat4(input logic [4:0] v);
    logic [3:0] r;
    if (v >= 5'd15) begin
      r = 4'd15;
    end else begin
      r = v[3:0];
    end
    return r;
  endfunction

`ifdef FTD_PARITY_EN
  // Even parity (XOR reduction) over a 32-bit word.
  function automatic logic par32(input logic [31:0] v);
    return ^v;
  endfunction
`endif

  // Raw source fields packed into single vectors. Low bits come first.
  // cdc: [3:0] t3f [7:4] t3s [11:8] t2f [15:12] t2s [16] bb [17] open45 [18] timing
  // ecl: [7:0] flags [8] e_high [19:9] bha_type [24:20] n_clus
  // top: [3:0] n_top [4] bb;  klm: [3:0] n_klm
  logic [18:0] cdc_in_s;
  logic [24:0] ecl_in_s;
  logic [4:0]  top_in_s;
  logic [3:0]  klm_in_s;
  logic [3:0]  valid_s;

  assign cdc_in_s = {cdc_timing, cdc_open45, cdc_bb, cdc_t2_short, cdc_t2_full,
                     cdc_t3_short, cdc_t3_full};
  assign ecl_in_s = {n_clus_raw, bha_type, e_high, ecl_flags};
  assign top_in_s = {top_bb, n_top_raw};
  assign klm_in_s = n_klm_raw;
  assign valid_s  = {klm_valid, top_valid, ecl_valid, cdc_valid};

  state_e              state_q, state_d;
  logic [3:0]          mask_q, mask_d;
  logic [7:0]          timer_q, timer_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                stray_q, stray_d;
  logic                dup_q, dup_d;
  logic [18:0]         cdc_q, cdc_d;
  logic [24:0]         ecl_q, ecl_d;
  logic [4:0]          top_q, top_d;
  logic [3:0]          klm_q, klm_d;
  logic [31:0]         ftdinb_q;
  logic [31:0]         ftdind_q;
  logic [29:0]         ftdinf_q;
  logic                frame_valid_q;

  logic                accept_s;
  logic [3:0]          base_mask_s;
  logic [3:0]          latch_en_s;
  logic [3:0]          new_mask_s;
  logic                dup_now_s;
  logic                stray_now_s;
  logic                emit_s;
  logic                timeout_s;
  logic                overlap_s;
  logic [3:0]          emit_mask_s;
  logic [18:0]         emit_cdc_s;
  logic [24:0]         emit_ecl_s;
  logic [4:0]          emit_top_s;
  logic [3:0]          emit_klm_s;

  // Frame bookkeeping. A frame_start always opens a fresh frame, so the
  // valids in that cycle latch against an empty mask. In any other COLLECT
  // cycle they latch against the mask built up so far.
  always_comb begin
    accept_s    = frame_start | (state_q == COLLECT);
    if (frame_start) begin
      base_mask_s = 4'b0000;
    end else begin
      base_mask_s = mask_q;
    end
    latch_en_s  = valid_s & ~base_mask_s & {4{accept_s}};
    new_mask_s  = base_mask_s | (valid_s & {4{accept_s}});
    dup_now_s   = (state_q == COLLECT) & ~frame_start & (|(valid_s & mask_q));
    stray_now_s = (state_q == IDLE) & ~frame_start & (|valid_s);
    cdc_d = latch_en_s[0] ? cdc_in_s : cdc_q;
    ecl_d = latch_en_s[1] ? ecl_in_s : ecl_q;
    top_d = latch_en_s[2] ? top_in_s : top_q;
    klm_d = latch_en_s[3] ? klm_in_s : klm_q;
  end

  // Next-state and emission decision.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    emit_s      = 1'b0;
    timeout_s   = 1'b0;
    overlap_s   = 1'b0;
    emit_mask_s = new_mask_s;
    emit_cdc_s  = cdc_d;
    emit_ecl_s  = ecl_d;
    emit_top_s  = top_d;
    emit_klm_s  = klm_d;
    case (state_q)
      IDLE: begin
        if (frame_start && (new_mask_s == 4'b1111)) begin
          emit_s  = 1'b1;
          mask_d  = 4'b0000;
          timer_d = 8'd0;
        end else if (frame_start) begin
          state_d = COLLECT;
          mask_d  = new_mask_s;
          timer_d = 8'd1;
        end else begin
          mask_d  = 4'b0000;
          timer_d = 8'd0;
        end
      end
      COLLECT: begin
        if (frame_start) begin
          // The old frame goes out with only what it had already latched.
          // This cycle's valids belong to the new frame.
          emit_s      = 1'b1;
          overlap_s   = 1'b1;
          emit_mask_s = mask_q;
          emit_cdc_s  = cdc_q;
          emit_ecl_s  = ecl_q;
          emit_top_s  = top_q;
          emit_klm_s  = klm_q;
          mask_d      = new_mask_s;
          timer_d     = 8'd1;
        end else if (new_mask_s == 4'b1111) begin
          // Completion takes priority over window end, so timeout stays 0.
          emit_s  = 1'b1;
          state_d = IDLE;
          mask_d  = 4'b0000;
          timer_d = 8'd0;
        end else if (timer_q == LAST_CYC) begin
          emit_s    = 1'b1;
          timeout_s = 1'b1;
          state_d   = IDLE;
          mask_d    = 4'b0000;
          timer_d   = 8'd0;
        end else begin
          mask_d  = new_mask_s;
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = 4'b0000;
        timer_d = 8'd0;
      end
    endcase
  end

  // Sticky flags and the frame counter advance with each emission.
  always_comb begin
    if (emit_s) begin
      stray_d = 1'b0;
      dup_d   = 1'b0;
      fcnt_d  = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
    end else begin
      stray_d = stray_q | stray_now_s;
      dup_d   = dup_q | dup_now_s;
      fcnt_d  = fcnt_q;
    end
  end

  logic [18:0] pk_cdc_s;
  logic [24:0] pk_ecl_s;
  logic [4:0]  pk_top_s;
  logic [3:0]  pk_klm_s;
  logic [3:0]  nclus_s;
  logic [15:0] fcnt_ext_s;
  logic [31:0] pack_b_s;
  logic [31:0] pack_d_s;
  logic [29:0] pack_f_s;

  // Pack the emitted frame. A missing source is forced to zero here, so
  // stale latched data from earlier frames never leaks out.
  always_comb begin
    pk_cdc_s   = emit_mask_s[0] ? emit_cdc_s : 19'd0;
    pk_ecl_s   = emit_mask_s[1] ? emit_ecl_s : 25'd0;
    pk_top_s   = emit_mask_s[2] ? emit_top_s : 5'd0;
    pk_klm_s   = emit_mask_s[3] ? emit_klm_s : 4'd0;
    nclus_s    = sat4(pk_ecl_s[24:20]);
    fcnt_ext_s = 16'(fcnt_q);

    pack_b_s        = 32'd0;
    pack_b_s[2:0]   = sat3(pk_cdc_s[3:0]);
    pack_b_s[5:3]   = sat3(pk_cdc_s[7:4]);
    pack_b_s[8:6]   = sat3(pk_cdc_s[11:8]);
    pack_b_s[11:9]  = sat3(pk_cdc_s[15:12]);
    pack_b_s[12]    = pk_cdc_s[16];
    pack_b_s[13]    = pk_cdc_s[17];
    pack_b_s[14]    = pk_cdc_s[18];
    pack_b_s[15]    = pk_ecl_s[8];
    pack_b_s[16]    = pk_ecl_s[0];
    pack_b_s[17]    = pk_ecl_s[1];
    pack_b_s[18]    = pk_ecl_s[2];
    pack_b_s[29:19] = pk_ecl_s[19:9];
    pack_b_s[31:30] = nclus_s[1:0];

    pack_d_s        = 32'd0;
    pack_d_s[1:0]   = nclus_s[3:2];
    pack_d_s[2]     = pk_ecl_s[3];
    pack_d_s[3]     = pk_ecl_s[4];
    pack_d_s[4]     = pk_ecl_s[5];
    pack_d_s[5]     = pk_ecl_s[6];
    pack_d_s[6]     = pk_ecl_s[7];
    pack_d_s[9:7]   = sat3(pk_top_s[3:0]);
    pack_d_s[10]    = pk_top_s[4];
    pack_d_s[13:11] = sat3(pk_klm_s);
    pack_d_s[14]    = revo;
    pack_d_s[15]    = her_kick;
    pack_d_s[16]    = ler_kick;
    pack_d_s[17]    = bha_delay;
    pack_d_s[18]    = pseude_rand;
    pack_d_s[19]    = veto;

    pack_f_s        = 30'd0;
    pack_f_s[3:0]   = ~emit_mask_s;
    pack_f_s[4]     = timeout_s;
    pack_f_s[5]     = overlap_s;
    pack_f_s[6]     = stray_q;
    pack_f_s[7]     = dup_q | dup_now_s;
    pack_f_s[23:8]  = fcnt_ext_s;
`ifdef FTD_PARITY_EN
    pack_f_s[28]    = par32(pack_b_s);
    pack_f_s[29]    = par32({12'd0, pack_d_s[19:0]});
`else
    pack_f_s[29:28] = 2'b00;
`endif
  end

  // State, latched fields and registered connector outputs.
  always_ff @(posedge gclk2) begin
    if (reset) begin
      state_q       <= IDLE;
      mask_q        <= 4'b0000;
      timer_q       <= 8'd0;
      fcnt_q        <= '0;
      stray_q       <= 1'b0;
      dup_q         <= 1'b0;
      cdc_q         <= 19'd0;
      ecl_q         <= 25'd0;
      top_q         <= 5'd0;
      klm_q         <= 4'd0;
      ftdinb_q      <= 32'd0;
      ftdind_q      <= 32'd0;
      ftdinf_q      <= 30'd0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      timer_q       <= timer_d;
      fcnt_q        <= fcnt_d;
      stray_q       <= stray_d;
      dup_q         <= dup_d;
      cdc_q         <= cdc_d;
      ecl_q         <= ecl_d;
      top_q         <= top_d;
      klm_q         <= klm_d;
      frame_valid_q <= emit_s;
      if (emit_s) begin
        ftdinb_q <= pack_b_s;
        ftdind_q <= pack_d_s;
        ftdinf_q <= pack_f_s;
      end
    end
  end

  assign ftdinb          = ftdinb_q;
  assign ftdind          = ftdind_q;
  assign ftdinf          = ftdinf_q;
  assign ftd_frame_valid = frame_valid_q;

endmodule

// File: tb/tb_ftd_input_packer.sv
// ---------------------------------------------------------------------------
// tb_ftd_input_packer
//
// Directed stimulus for ftd_input_packer. Each frame pushes its
// hand-computed connector words and arrival cycle into a scoreboard queue.
// A monitor process pops and compares them on every ftd_frame_valid strobe.
// ---------------------------------------------------------------------------
module tb_ftd_input_packer;

  localparam int WINDOW = 8;

`ifdef FTD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        gclk2 = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        cdc_valid;
  logic [3:0]  cdc_t3_full, cdc_t3_short, cdc_t2_full, cdc_t2_short;
  logic        cdc_bb, cdc_open45, cdc_timing;
  logic        ecl_valid;
  logic [7:0]  ecl_flags;
  logic        e_high;
  logic [10:0] bha_type;
  logic [4:0]  n_clus_raw;
  logic        top_valid;
  logic [3:0]  n_top_raw;
  logic        top_bb;
  logic        klm_valid;
  logic [3:0]  n_klm_raw;
  logic        revo, her_kick, ler_kick, bha_delay, pseude_rand, veto;
  logic [31:0] ftdinb;
  logic [31:0] ftdind;
  logic [29:0] ftdinf;
  logic        ftd_frame_valid;

  ftd_input_packer #(.WINDOW(WINDOW), .FCNT_W(16)) dut (
    .gclk2(gclk2), .reset(reset), .frame_start(frame_start),
    .cdc_valid(cdc_valid), .cdc_t3_full(cdc_t3_full), .cdc_t3_short(cdc_t3_short),
    .cdc_t2_full(cdc_t2_full), .cdc_t2_short(cdc_t2_short),
    .cdc_bb(cdc_bb), .cdc_open45(cdc_open45), .cdc_timing(cdc_timing),
    .ecl_valid(ecl_valid), .ecl_flags(ecl_flags), .e_high(e_high),
    .bha_type(bha_type), .n_clus_raw(n_clus_raw),
    .top_valid(top_valid), .n_top_raw(n_top_raw), .top_bb(top_bb),
    .klm_valid(klm_valid), .n_klm_raw(n_klm_raw),
    .revo(revo), .her_kick(her_kick), .ler_kick(ler_kick),
    .bha_delay(bha_delay), .pseude_rand(pseude_rand), .veto(veto),
    .ftdinb(ftdinb), .ftdind(ftdind), .ftdinf(ftdinf),
    .ftd_frame_valid(ftd_frame_valid)
  );

  always #5 gclk2 = ~gclk2;

  int cyc = 0;
  always @(posedge gclk2) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] b;
    logic [31:0] d;
    logic [29:0] f;
    int          at;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Queue one expected frame. flags = ftdinf[7:0], cnt = frame counter,
  // lat = clock edges from now until the strobe becomes visible.
  task automatic push(input string nm, input logic [31:0] b, input logic [31:0] d,
                      input logic [7:0] flags, input logic [15:0] cnt, input int lat);
    exp_t e;
    logic [1:0] par;
    par    = PAR_EN ? {^d[19:0], ^b} : 2'b00;
    e.b    = b;
    e.d    = d;
    e.f    = {par, 4'd0, cnt, flags};
    e.at   = cyc + lat;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge gclk2);
      if (ftd_frame_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_cyc"}, 32'(cyc), 32'(e.at));
          check({e.name, "_b"}, ftdinb, e.b);
          check({e.name, "_d"}, ftdind, e.d);
          check({e.name, "_f"}, {2'b00, ftdinf}, {2'b00, e.f});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge gclk2);
    #1;
  endtask

  task automatic clr();
    frame_start = 1'b0;
    cdc_valid = 1'b0; ecl_valid = 1'b0; top_valid = 1'b0; klm_valid = 1'b0;
    cdc_t3_full = 4'd0; cdc_t3_short = 4'd0; cdc_t2_full = 4'd0; cdc_t2_short = 4'd0;
    cdc_bb = 1'b0; cdc_open45 = 1'b0; cdc_timing = 1'b0;
    ecl_flags = 8'd0; e_high = 1'b0; bha_type = 11'd0; n_clus_raw = 5'd0;
    n_top_raw = 4'd0; top_bb = 1'b0; n_klm_raw = 4'd0;
    revo = 1'b0; her_kick = 1'b0; ler_kick = 1'b0;
    bha_delay = 1'b0; pseude_rand = 1'b0; veto = 1'b0;
  endtask

  task automatic all_valid();
    frame_start = 1'b1;
    cdc_valid = 1'b1; ecl_valid = 1'b1; top_valid = 1'b1; klm_valid = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    clr();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_b", ftdinb, 32'd0);
    check("rst_d", ftdind, 32'd0);
    check("rst_f", {2'b00, ftdinf}, 32'd0);
    check("rst_valid", {31'd0, ftd_frame_valid}, 32'd0);
    reset = 1'b0;
    tick();

    // All sources arrive with frame_start, so the frame emits after 1 cycle.
    all_valid(); cdc_t3_full = 4'd2; n_clus_raw = 5'd5;
    push("t1_min_lat", 32'h4000_0002, 32'h0000_0001, 8'h00, 16'd0, 1);
    tick(); clr(); tick();

    // Only CDC and ECL arrive, so the frame times out. revo is raised only in window cycle 7.
    frame_start = 1'b1; cdc_valid = 1'b1; ecl_valid = 1'b1;
    cdc_t3_full = 4'd3; ecl_flags = 8'h01;
    push("t2_timeout", 32'h0001_0003, 32'h0000_4000, 8'h1C, 16'd1, WINDOW);
    tick(); clr();
    repeat (WINDOW - 2) tick();
    revo = 1'b1;
    tick(); clr(); tick();

    // Saturation of the packed counts.
    all_valid(); cdc_t2_short = 4'd12; n_clus_raw = 5'd31; n_klm_raw = 4'd9;
    n_top_raw = 4'd8; bha_type = 11'h555;
    push("t3_sat", 32'hEAA8_0E00, 32'h0000_3B83, 8'h00, 16'd2, 1);
    tick(); clr(); tick();

    // A second frame_start arrives in window cycle 3 while only CDC has been latched.
    frame_start = 1'b1; cdc_valid = 1'b1; cdc_t3_short = 4'd5;
    push("t4_overlap", 32'h0000_0028, 32'h0000_0000, 8'h2E, 16'd3, 4);
    tick(); clr(); tick(); tick();
    frame_start = 1'b1; top_valid = 1'b1; klm_valid = 1'b1;
    n_top_raw = 4'd2; top_bb = 1'b1; n_klm_raw = 4'd3;
    push("t4_second", 32'h0000_9000, 32'h0000_1D00, 8'h00, 16'd4, 2);
    tick(); clr();
    ecl_valid = 1'b1; e_high = 1'b1; cdc_valid = 1'b1; cdc_bb = 1'b1;
    tick(); clr(); tick();

    // A stray ECL valid arrives in IDLE, then CDC is duplicated in the frame.
    ecl_valid = 1'b1; ecl_flags = 8'hFF;
    tick(); clr(); tick();
    frame_start = 1'b1; cdc_valid = 1'b1; cdc_t2_full = 4'd4;
    push("t5_dupstray", 32'h0000_0100, 32'h0000_0000, 8'hC0, 16'd5, 3);
    tick(); clr();
    cdc_valid = 1'b1; cdc_t2_full = 4'd1;
    tick(); clr();
    ecl_valid = 1'b1; top_valid = 1'b1; klm_valid = 1'b1;
    tick(); clr(); tick();
    all_valid(); cdc_t3_full = 4'd1;
    push("t5_clear", 32'h0000_0001, 32'h0000_0000, 8'h00, 16'd6, 1);
    tick(); clr(); tick();

    // Reset in the middle of COLLECT discards the frame and clears the outputs and counter.
    frame_start = 1'b1; cdc_valid = 1'b1; cdc_t3_full = 4'd1;
    tick(); clr(); tick();
    reset = 1'b1;
    tick();
    check("rst_mid_b", ftdinb, 32'd0);
    check("rst_mid_d", ftdind, 32'd0);
    check("rst_mid_f", {2'b00, ftdinf}, 32'd0);
    check("rst_mid_valid", {31'd0, ftd_frame_valid}, 32'd0);
    reset = 1'b0;
    repeat (WINDOW + 2) tick();
    all_valid(); n_klm_raw = 4'd7;
    push("t6_after_rst", 32'h0000_0000, 32'h0000_3800, 8'h00, 16'd0, 1);
    tick(); clr(); tick();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d frames pending, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
